// File: rtl/rv_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_decode_unit
// Description : Decode stage of the brisc in-order RV32 pipeline. Decodes one
//               RV32I/M instruction per cycle into a 5-bit instruction code,
//               a sign-extended immediate and a destination register, reads
//               two operands from a 32-entry register file with write-through
//               forwarding, and registers the result into the decode/execute
//               pipeline register under stall control.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_decode_unit #(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int REG_BITS    = 5,
  parameter int OPCODE_BITS = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_decode,
  input  logic [ILEN-1:0]        instr_in,
  input  logic [OPCODE_BITS-1:0] opcode_wb_in,
  input  logic [XLEN-1:0]        data_wb_in,
  input  logic [REG_BITS-1:0]    rd_wb_in,
  input  logic                   rf_enable,
  output logic [REG_BITS-1:0]    rd_out,
  output logic [XLEN-1:0]        rs1_data_out,
  output logic [XLEN-1:0]        rs2_data_out,
  output logic [XLEN-1:0]        imm_out,
  output logic [4:0]             instr_out,
  output logic                   xcpt
);

  localparam int NUM_REGS = 1 << REG_BITS;

  // Major opcodes handled by this decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction codes presented to the execute stage
  localparam logic [4:0] C_INVALID = 5'd0;
  localparam logic [4:0] C_ADD     = 5'd1;
  localparam logic [4:0] C_SUB     = 5'd2;
  localparam logic [4:0] C_MUL     = 5'd3;
  localparam logic [4:0] C_AND     = 5'd4;
  localparam logic [4:0] C_OR      = 5'd5;
  localparam logic [4:0] C_XOR     = 5'd6;
  localparam logic [4:0] C_SLL     = 5'd7;
  localparam logic [4:0] C_SRL     = 5'd8;
  localparam logic [4:0] C_ADDI    = 5'd9;
  localparam logic [4:0] C_LW      = 5'd10;
  localparam logic [4:0] C_LB      = 5'd11;
  localparam logic [4:0] C_SW      = 5'd12;
  localparam logic [4:0] C_SB      = 5'd13;
  localparam logic [4:0] C_BEQ     = 5'd14;
  localparam logic [4:0] C_BNE     = 5'd15;
  localparam logic [4:0] C_BLT     = 5'd16;
  localparam logic [4:0] C_BGE     = 5'd17;
  localparam logic [4:0] C_JAL     = 5'd18;
  localparam logic [4:0] C_JALR    = 5'd19;
  localparam logic [4:0] C_LUI     = 5'd20;
  localparam logic [4:0] C_AUIPC   = 5'd21;

  // Immediate format selector
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // The writeback opcode is carried for future use and has no effect today
  logic unused_opcode_wb;
  assign unused_opcode_wb = ^opcode_wb_in;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [REG_BITS-1:0] rs1_idx;
  logic [REG_BITS-1:0] rs2_idx;
  logic [REG_BITS-1:0] rd_idx;

  assign opcode  = instr_in[6:0];
  assign funct3  = instr_in[14:12];
  assign funct7  = instr_in[31:25];
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];
  assign rd_idx  = instr_in[11:7];

  // Candidate immediates for every format, all sign-extended from bit 31
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = XLEN'($signed({instr_in[31:12], 12'b0}));
  assign imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  logic [4:0]          dec_code;
  logic [2:0]          dec_fmt;
  logic                dec_has_rd;
  logic [XLEN-1:0]     dec_imm;
  logic [REG_BITS-1:0] dec_rd;

  // Classify the instruction into a code, immediate format and rd usage
  always_comb begin
    dec_code   = C_INVALID;
    dec_fmt    = FMT_R;
    dec_has_rd = 1'b0;
    case (opcode)
      OP_R: begin
        dec_fmt    = FMT_R;
        dec_has_rd = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_code = C_ADD;
          {7'b0100000, 3'b000}: dec_code = C_SUB;
          {7'b0000001, 3'b000}: dec_code = C_MUL;
          {7'b0000000, 3'b111}: dec_code = C_AND;
          {7'b0000000, 3'b110}: dec_code = C_OR;
          {7'b0000000, 3'b100}: dec_code = C_XOR;
          {7'b0000000, 3'b001}: dec_code = C_SLL;
          {7'b0000000, 3'b101}: dec_code = C_SRL;
          default:              dec_code = C_INVALID;
        endcase
      end
      OP_IMM: begin
        dec_fmt    = FMT_I;
        dec_has_rd = 1'b1;
        if (funct3 == 3'b000) dec_code = C_ADDI;
      end
      OP_LOAD: begin
        dec_fmt    = FMT_I;
        dec_has_rd = 1'b1;
        case (funct3)
          3'b010:  dec_code = C_LW;
          3'b000:  dec_code = C_LB;
          default: dec_code = C_INVALID;
        endcase
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        case (funct3)
          3'b010:  dec_code = C_SW;
          3'b000:  dec_code = C_SB;
          default: dec_code = C_INVALID;
        endcase
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        case (funct3)
          3'b000:  dec_code = C_BEQ;
          3'b001:  dec_code = C_BNE;
          3'b100:  dec_code = C_BLT;
          3'b101:  dec_code = C_BGE;
          default: dec_code = C_INVALID;
        endcase
      end
      OP_JAL: begin
        dec_fmt    = FMT_J;
        dec_has_rd = 1'b1;
        dec_code   = C_JAL;
      end
      OP_JALR: begin
        dec_fmt    = FMT_I;
        dec_has_rd = 1'b1;
        if (funct3 == 3'b000) dec_code = C_JALR;
      end
      OP_LUI: begin
        dec_fmt    = FMT_U;
        dec_has_rd = 1'b1;
        dec_code   = C_LUI;
      end
      OP_AUIPC: begin
        dec_fmt    = FMT_U;
        dec_has_rd = 1'b1;
        dec_code   = C_AUIPC;
      end
      default: dec_code = C_INVALID;
    endcase
  end

  // Pick the immediate and destination; illegal encodings yield zeros
  always_comb begin
    dec_imm = '0;
    dec_rd  = '0;
    if (dec_code != C_INVALID) begin
      case (dec_fmt)
        FMT_I:   dec_imm = imm_i;
        FMT_S:   dec_imm = imm_s;
        FMT_B:   dec_imm = imm_b;
        FMT_U:   dec_imm = imm_u;
        FMT_J:   dec_imm = imm_j;
        default: dec_imm = '0;
      endcase
      if (dec_has_rd) dec_rd = rd_idx;
    end
  end

  assign xcpt = (dec_code == C_INVALID);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wb_en;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // x0 is never written, so a writeback targeting it is simply dropped
  assign wb_en = rf_enable && (rd_wb_in != '0);

  // Writeback port; runs regardless of stall_decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[rd_wb_in] <= data_wb_in;
    end
  end

  // Read port 1 with same-cycle forwarding of the writeback data
  always_comb begin
    rs1_data = '0;
    if (rs1_idx != '0) begin
      if (wb_en && (rd_wb_in == rs1_idx)) rs1_data = data_wb_in;
      else                                rs1_data = regs[rs1_idx];
    end
  end

  // Read port 2 with same-cycle forwarding of the writeback data
  always_comb begin
    rs2_data = '0;
    if (rs2_idx != '0) begin
      if (wb_en && (rd_wb_in == rs2_idx)) rs2_data = data_wb_in;
      else                                rs2_data = regs[rs2_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Decode/execute pipeline register
  // --------------------------------------------------------------------------
  // Capture the decoded bundle unless the stage is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_out       <= '0;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      imm_out      <= '0;
      instr_out    <= C_INVALID;
    end else if (!stall_decode) begin
      rd_out       <= dec_rd;
      rs1_data_out <= rs1_data;
      rs2_data_out <= rs2_data;
      imm_out      <= dec_imm;
      instr_out    <= dec_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_decode_unit
// Description : Self-checking bench for rv_decode_unit: directed vectors,
//               hand-written stall/writeback/reset sequences and randomized
//               traffic against a pattern-matching reference decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_decode;
  logic [31:0] instr_in;
  logic [6:0]  opcode_wb_in;
  logic [31:0] data_wb_in;
  logic [4:0]  rd_wb_in;
  logic        rf_enable;
  logic [4:0]  rd_out;
  logic [31:0] rs1_data_out;
  logic [31:0] rs2_data_out;
  logic [31:0] imm_out;
  logic [4:0]  instr_out;
  logic        xcpt;

  always #5 clk = ~clk;

  rv_decode_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_decode (stall_decode),
    .instr_in     (instr_in),
    .opcode_wb_in (opcode_wb_in),
    .data_wb_in   (data_wb_in),
    .rd_wb_in     (rd_wb_in),
    .rf_enable    (rf_enable),
    .rd_out       (rd_out),
    .rs1_data_out (rs1_data_out),
    .rs2_data_out (rs2_data_out),
    .imm_out      (imm_out),
    .instr_out    (instr_out),
    .xcpt         (xcpt)
  );

  int total = 0;
  int bad   = 0;

  // Instruction patterns: an instruction matches when (instr & mask) == match
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  code;
    int          fmt;   // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
  } pat_t;
  pat_t pats[21];

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  code;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;
  vec_t vecs[$];

  // Reference state
  logic [31:0] mrf [32];
  logic [4:0]  exp_rd;
  logic [31:0] exp_rs1;
  logic [31:0] exp_rs2;
  logic [31:0] exp_imm;
  logic [4:0]  exp_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] code,
                                     output logic [31:0] imm, output logic [4:0] rd);
    logic [31:0] sign;
    sign = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    code = 5'd0;
    imm  = 32'h0;
    rd   = 5'd0;
    for (int k = 0; k < 21; k++) begin
      if ((ins & pats[k].mask) == pats[k].match) begin
        code = pats[k].code;
        case (pats[k].fmt)
          1: imm = (sign << 12) | (ins >> 20);
          2: imm = (sign << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
          3: imm = (sign << 12) | (((ins >> 7) & 32'h1) << 11) |
                   (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
          4: imm = ins & 32'hFFFF_F000;
          5: imm = (sign << 20) | (((ins >> 12) & 32'hFF) << 12) |
                   (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
          default: imm = 32'h0;
        endcase
        rd = (pats[k].fmt == 2 || pats[k].fmt == 3) ? 5'd0 : ins[11:7];
      end
    end
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rf_enable && rd_wb_in != 5'd0 && rd_wb_in == a) return data_wb_in;
    return mrf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    exp_rd = 0; exp_rs1 = 0; exp_rs2 = 0; exp_imm = 0; exp_code = 0;
  endtask

  // One clock: inputs already driven; checks xcpt before the edge and the
  // pipeline register after it against the reference model.
  task automatic cycle();
    logic [4:0]  c;
    logic [31:0] im;
    logic [4:0]  r;
    logic [31:0] v1;
    logic [31:0] v2;
    #1;
    ref_decode(instr_in, c, im, r);
    v1 = ref_read(instr_in[19:15]);
    v2 = ref_read(instr_in[24:20]);
    chk("xcpt", {31'b0, xcpt}, {31'b0, (c == 5'd0)});
    if (!stall_decode) begin
      exp_rd = r; exp_rs1 = v1; exp_rs2 = v2; exp_imm = im; exp_code = c;
    end
    if (rf_enable && rd_wb_in != 5'd0) mrf[rd_wb_in] = data_wb_in;
    @(posedge clk);
    #1;
    chk("rd_out",       {27'b0, rd_out},    {27'b0, exp_rd});
    chk("rs1_data_out", rs1_data_out,       exp_rs1);
    chk("rs2_data_out", rs2_data_out,       exp_rs2);
    chk("imm_out",      imm_out,            exp_imm);
    chk("instr_out",    {27'b0, instr_out}, {27'b0, exp_code});
  endtask

  initial begin
    pats[0]  = '{32'hFE00707F, 32'h00000033, 5'd1,  0};
    pats[1]  = '{32'hFE00707F, 32'h40000033, 5'd2,  0};
    pats[2]  = '{32'hFE00707F, 32'h02000033, 5'd3,  0};
    pats[3]  = '{32'hFE00707F, 32'h00007033, 5'd4,  0};
    pats[4]  = '{32'hFE00707F, 32'h00006033, 5'd5,  0};
    pats[5]  = '{32'hFE00707F, 32'h00004033, 5'd6,  0};
    pats[6]  = '{32'hFE00707F, 32'h00001033, 5'd7,  0};
    pats[7]  = '{32'hFE00707F, 32'h00005033, 5'd8,  0};
    pats[8]  = '{32'h0000707F, 32'h00000013, 5'd9,  1};
    pats[9]  = '{32'h0000707F, 32'h00002003, 5'd10, 1};
    pats[10] = '{32'h0000707F, 32'h00000003, 5'd11, 1};
    pats[11] = '{32'h0000707F, 32'h00002023, 5'd12, 2};
    pats[12] = '{32'h0000707F, 32'h00000023, 5'd13, 2};
    pats[13] = '{32'h0000707F, 32'h00000063, 5'd14, 3};
    pats[14] = '{32'h0000707F, 32'h00001063, 5'd15, 3};
    pats[15] = '{32'h0000707F, 32'h00004063, 5'd16, 3};
    pats[16] = '{32'h0000707F, 32'h00005063, 5'd17, 3};
    pats[17] = '{32'h0000007F, 32'h0000006F, 5'd18, 5};
    pats[18] = '{32'h0000707F, 32'h00000067, 5'd19, 1};
    pats[19] = '{32'h0000007F, 32'h00000037, 5'd20, 4};
    pats[20] = '{32'h0000007F, 32'h00000017, 5'd21, 4};

    // {instr, code, imm, rd}
    vecs.push_back('{32'hFE20AE23, 5'd12, 32'hFFFFFFFC, 5'd0});  // sw x2,-4(x1)
    vecs.push_back('{32'hFE000CE3, 5'd14, 32'hFFFFFFF8, 5'd0});  // beq x0,x0,-8
    vecs.push_back('{32'h12345237, 5'd20, 32'h12345000, 5'd4});  // lui x4,0x12345
    vecs.push_back('{32'hFFF00113, 5'd9,  32'hFFFFFFFF, 5'd2});  // addi x2,x0,-1
    vecs.push_back('{32'h000180B3, 5'd1,  32'h00000000, 5'd1});  // add
    vecs.push_back('{32'h403100B3, 5'd2,  32'h00000000, 5'd1});  // sub
    vecs.push_back('{32'h023100B3, 5'd3,  32'h00000000, 5'd1});  // mul
    vecs.push_back('{32'h008000EF, 5'd18, 32'h00000008, 5'd1});  // jal x1,8
    vecs.push_back('{32'h00008067, 5'd19, 32'h00000000, 5'd0});  // jalr x0,0(x1)
    vecs.push_back('{32'hFFFFF297, 5'd21, 32'hFFFFF000, 5'd5});  // auipc x5
    vecs.push_back('{32'h01012183, 5'd10, 32'h00000010, 5'd3});  // lw x3,16(x2)
    vecs.push_back('{32'h00000003, 5'd11, 32'h00000000, 5'd0});  // lb
    vecs.push_back('{32'h00000023, 5'd13, 32'h00000000, 5'd0});  // sb
    vecs.push_back('{32'h00001063, 5'd15, 32'h00000000, 5'd0});  // bne
    vecs.push_back('{32'h00004063, 5'd16, 32'h00000000, 5'd0});  // blt
    vecs.push_back('{32'h00005063, 5'd17, 32'h00000000, 5'd0});  // bge
    vecs.push_back('{32'h400070B3, 5'd0,  32'h00000000, 5'd0});  // funct7 0100000 funct3 111
    vecs.push_back('{32'h40005033, 5'd0,  32'h00000000, 5'd0});  // sra (unsupported)
    vecs.push_back('{32'h00001013, 5'd0,  32'h00000000, 5'd0});  // slli (unsupported)
    vecs.push_back('{32'hFFFFFFFF, 5'd0,  32'h00000000, 5'd0});
    vecs.push_back('{32'h00000000, 5'd0,  32'h00000000, 5'd0});

    // Reset: asserted between edges, outputs must clear immediately
    reset = 1'b1; stall_decode = 1'b0; instr_in = 32'h0; opcode_wb_in = 7'h0;
    data_wb_in = 32'h0; rd_wb_in = 5'd0; rf_enable = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("reset rd_out",    {27'b0, rd_out},    32'h0);
    chk("reset rs1_data",  rs1_data_out,       32'h0);
    chk("reset rs2_data",  rs2_data_out,       32'h0);
    chk("reset imm_out",   imm_out,            32'h0);
    chk("reset instr_out", {27'b0, instr_out}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed decode vectors
    for (int i = 0; i < vecs.size(); i++) begin
      instr_in = vecs[i].instr;
      cycle();
      chk("vec code", {27'b0, instr_out}, {27'b0, vecs[i].code});
      chk("vec imm",  imm_out,            vecs[i].imm);
      chk("vec rd",   {27'b0, rd_out},    {27'b0, vecs[i].rd});
    end

    // Writeback with write-through into the decoded operand
    rf_enable = 1'b1; rd_wb_in = 5'd3; data_wb_in = 32'hDEADBEEF;
    instr_in = 32'h000180B3;
    cycle();
    chk("wt rs1", rs1_data_out, 32'hDEADBEEF);
    chk("wt rs2", rs2_data_out, 32'h0);
    chk("wt rd",  {27'b0, rd_out},    32'd1);
    chk("wt code", {27'b0, instr_out}, 32'd1);

    // x0 protection
    rd_wb_in = 5'd0; data_wb_in = 32'h55; instr_in = 32'h00000013;
    cycle();
    rf_enable = 1'b0; instr_in = 32'hFFF00113;
    cycle();
    chk("x0 rs1",  rs1_data_out,       32'h0);
    chk("x0 imm",  imm_out,            32'hFFFFFFFF);
    chk("x0 code", {27'b0, instr_out}, 32'd9);
    chk("x0 rd",   {27'b0, rd_out},    32'd2);

    // Stall holds outputs while xcpt follows the new instruction
    instr_in = 32'h000180B3;
    cycle();
    stall_decode = 1'b1; instr_in = 32'hFFFFFFFF;
    #1 chk("stall xcpt", {31'b0, xcpt}, 32'd1);
    cycle();
    chk("stall hold code", {27'b0, instr_out}, 32'd1);
    chk("stall hold rs1",  rs1_data_out,       32'hDEADBEEF);
    stall_decode = 1'b0;
    cycle();
    chk("unstall code", {27'b0, instr_out}, 32'd0);
    chk("unstall rd",   {27'b0, rd_out},    32'd0);
    chk("unstall imm",  imm_out,            32'd0);

    // Writeback during a stall still updates the register file
    stall_decode = 1'b1; rf_enable = 1'b1; rd_wb_in = 5'd7; data_wb_in = 32'h1234;
    instr_in = 32'h000380B3;
    cycle();
    chk("wbstall hold code", {27'b0, instr_out}, 32'd0);
    stall_decode = 1'b0; rf_enable = 1'b0;
    cycle();
    chk("wbstall rs1", rs1_data_out, 32'h1234);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        int p;
        p = $urandom_range(0, 20);
        instr_in = pats[p].match | ($urandom & ~pats[p].mask);
      end else begin
        instr_in = $urandom;
      end
      stall_decode = ($urandom_range(0, 3) == 0);
      rf_enable    = $urandom_range(0, 1) == 1;
      rd_wb_in     = ($urandom_range(0, 3) == 0) ? instr_in[19:15] : 5'($urandom_range(0, 31));
      data_wb_in   = $urandom;
      cycle();
    end

    // Reset mid-operation clears the register file and outputs
    stall_decode = 1'b0; rf_enable = 1'b1; rd_wb_in = 5'd5; data_wb_in = 32'd7;
    instr_in = 32'hFFF00113;
    cycle();
    rf_enable = 1'b0; instr_in = 32'h000280B3;
    cycle();
    chk("pre-reset x5", rs1_data_out, 32'd7);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midreset rd_out",    {27'b0, rd_out},    32'h0);
    chk("midreset rs1_data",  rs1_data_out,       32'h0);
    chk("midreset rs2_data",  rs2_data_out,       32'h0);
    chk("midreset imm_out",   imm_out,            32'h0);
    chk("midreset instr_out", {27'b0, instr_out}, 32'h0);
    #1 reset = 1'b1;
    cycle();
    chk("post-reset x5", rs1_data_out, 32'h0);
    chk("post-reset code", {27'b0, instr_out}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
